pipeline_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage pipeline. It drives the write-enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves a post-reset drain, data-memory wait stalls, taken-branch flushes and load-use interlocks, and it keeps a stall statistic and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The pipeline side drives hazard sources; the controller drives enables, flushes and status.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  idRS;
  logic [4:0]  idRT;
  logic        idUsesRS;
  logic        idUsesRT;
  logic        exMemRead;
  logic [4:0]  exDstReg;
  logic        exBranchTaken;
  logic        memAccess;
  logic        memReady;
  logic        pcWrite;
  logic        ifidWrite;
  logic        idexWrite;
  logic        exmemWrite;
  logic        ifidFlush;
  logic        idexFlush;
  logic        exmemFlush;
  logic        memwbFlush;
  logic [1:0]  ctrlState;
  logic [15:0] stallCount;
  logic        memTimeout;

  modport master (
    output idRS, idRT, idUsesRS, idUsesRT, exMemRead, exDstReg,
           exBranchTaken, memAccess, memReady,
    input  pcWrite, ifidWrite, idexWrite, exmemWrite,
           ifidFlush, idexFlush, exmemFlush, memwbFlush,
           ctrlState, stallCount, memTimeout
  );

  modport slave (
    input  idRS, idRT, idUsesRS, idUsesRT, exMemRead, exDstReg,
           exBranchTaken, memAccess, memReady,
    output pcWrite, ifidWrite, idexWrite, exmemWrite,
           ifidFlush, idexFlush, exmemFlush, memwbFlush,
           ctrlState, stallCount, memTimeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: post-reset drain, memory wait,
// branch flush and load-use interlock, plus stall statistics and a sticky memory timeout.
//
// state    | meaning
// INIT     | draining the pipeline after reset; everything flushed
// RUN      | normal issue; hazards resolved combinationally
// MEM_WAIT | data memory access outstanding; whole pipeline frozen
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int TIMEOUT     = 255
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    UNUSED   = 2'd3
  } ctrlState_t;

  ctrlState_t  state;
  logic [3:0]  initCnt;
  logic [7:0]  waitCnt;
  logic [15:0] stallCount;
  logic        memTimeout;

  logic memStall;
  logic loadUse;
  logic pcWrite, ifidWrite, idexWrite, exmemWrite;
  logic ifidFlush, idexFlush, exmemFlush, memwbFlush;

  assign memStall = bus.memAccess & ~bus.memReady;
  assign loadUse  = bus.exMemRead & (bus.exDstReg != 5'd0) &
                    ((bus.idUsesRS & (bus.idRS == bus.exDstReg)) |
                     (bus.idUsesRT & (bus.idRT == bus.exDstReg)));

  // MEM_WAIT shares the RUN decision tree; only the state update differs.
  always_comb begin
    pcWrite    = 1'b0;
    ifidWrite  = 1'b0;
    idexWrite  = 1'b0;
    exmemWrite = 1'b0;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    exmemFlush = 1'b0;
    memwbFlush = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        if (memStall) begin
          memwbFlush = 1'b1;
        end else if (bus.exBranchTaken) begin
          pcWrite    = 1'b1;
          ifidWrite  = 1'b1;
          idexWrite  = 1'b1;
          exmemWrite = 1'b1;
          ifidFlush  = 1'b1;
          idexFlush  = 1'b1;
        end else if (loadUse) begin
          idexWrite  = 1'b1;
          idexFlush  = 1'b1;
          exmemWrite = 1'b1;
        end else begin
          pcWrite    = 1'b1;
          ifidWrite  = 1'b1;
          idexWrite  = 1'b1;
          exmemWrite = 1'b1;
        end
      end
      default: begin
        ifidFlush  = 1'b1;
        idexFlush  = 1'b1;
        exmemFlush = 1'b1;
        memwbFlush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      initCnt    <= 4'd0;
      waitCnt    <= 8'd0;
      stallCount <= 16'd0;
      memTimeout <= 1'b0;
    end else begin
      if (!pcWrite && state != INIT && stallCount != 16'hFFFF)
        stallCount <= stallCount + 16'd1;
      case (state)
        INIT: begin
          if (initCnt == 4'(INIT_CYCLES - 1)) begin
            state   <= RUN;
            initCnt <= 4'd0;
          end else begin
            initCnt <= initCnt + 4'd1;
          end
        end
        RUN: begin
          if (memStall) begin
            state   <= MEM_WAIT;
            waitCnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (memStall) begin
            if (waitCnt == 8'(TIMEOUT))
              memTimeout <= 1'b1;
            if (waitCnt != 8'hFF)
              waitCnt <= waitCnt + 8'd1;
          end else begin
            state   <= RUN;
            waitCnt <= 8'd0;
          end
        end
        default: begin
          state   <= INIT;
          initCnt <= 4'd0;
        end
      endcase
    end
  end

  assign bus.pcWrite    = pcWrite;
  assign bus.ifidWrite  = ifidWrite;
  assign bus.idexWrite  = idexWrite;
  assign bus.exmemWrite = exmemWrite;
  assign bus.ifidFlush  = ifidFlush;
  assign bus.idexFlush  = idexFlush;
  assign bus.exmemFlush = exmemFlush;
  assign bus.memwbFlush = memwbFlush;
  assign bus.ctrlState  = state;
  assign bus.stallCount = stallCount;
  assign bus.memTimeout = memTimeout;

endmodule
